// File: rtl/imem_ctrl.sv
// Instruction-memory port sequencer: arbitrates the fetch stage and the program loader
// onto one single-port synchronous RAM and returns fetch responses with backpressure.
module imem_ctrl #(
  parameter int          AW             = 5,
  parameter int          MAX_LOAD_BURST = 4,
  parameter logic [31:0] NOP_INSTR      = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req_valid,
  output logic          fetch_req_ready,
  input  logic [31:0]   fetch_addr,
  input  logic          fetch_flush,
  output logic          fetch_rsp_valid,
  input  logic          fetch_rsp_ready,
  output logic [31:0]   fetch_rsp_instr,
  output logic          fetch_rsp_err,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int SW = $clog2(MAX_LOAD_BURST + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LOAD_BURST);

  logic          rd_pending;
  logic          pend_err;
  logic          held_valid;
  logic          held_err;
  logic [31:0]   held_instr;
  logic [SW-1:0] streak;
  logic [AW-1:0] last_addr;
  logic [31:0]   last_wdata;

  logic          fetch_err;
  logic          port_free;
  logic          fetch_grant;
  logic          load_grant;
  logic          fetch_rd;
  logic          rsp_valid;
  logic [31:0]   pres_instr;
  logic          pres_err;

  // A response is either the live read result (cycle after grant) or the hold register.
  always_comb begin
    fetch_err  = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:AW+2] != '0);
    rsp_valid  = held_valid || rd_pending;
    pres_instr = '0;
    pres_err   = 1'b0;
    if (held_valid) begin
      pres_instr = held_instr;
      pres_err   = held_err;
    end else if (rd_pending) begin
      pres_instr = pend_err ? NOP_INSTR : mem_rdata;
      pres_err   = pend_err;
    end

    port_free   = !rsp_valid || fetch_rsp_ready || fetch_flush;
    fetch_grant = !rst && fetch_req_valid && port_free &&
                  (!load_valid || (streak == STREAK_MAX));
    load_grant  = !rst && load_valid && !fetch_grant;
    fetch_rd    = fetch_grant && !fetch_err;

    mem_en    = fetch_rd || load_grant;
    mem_we    = load_grant;
    mem_addr  = last_addr;
    mem_wdata = last_wdata;
    if (load_grant) begin
      mem_addr  = load_addr;
      mem_wdata = load_data;
    end else if (fetch_rd) begin
      mem_addr = fetch_addr[AW+1:2];
    end
  end

  assign fetch_req_ready = fetch_grant;
  assign load_ready      = load_grant;
  assign fetch_rsp_valid = rsp_valid;
  assign fetch_rsp_instr = pres_instr;
  assign fetch_rsp_err   = pres_err;

  // An unaccepted live response is frozen into the hold register so later reads can't disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pending <= 1'b0;
      pend_err   <= 1'b0;
      held_valid <= 1'b0;
      held_err   <= 1'b0;
      held_instr <= '0;
    end else begin
      rd_pending <= fetch_grant;
      pend_err   <= fetch_grant && fetch_err;
      if (rd_pending && !fetch_rsp_ready && !fetch_flush) begin
        held_valid <= 1'b1;
        held_instr <= pres_instr;
        held_err   <= pres_err;
      end else if (held_valid && (fetch_rsp_ready || fetch_flush)) begin
        held_valid <= 1'b0;
      end
    end
  end

  // Streak saturates so a loader granted while the port is busy can't skip past the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak     <= '0;
      last_addr  <= '0;
      last_wdata <= '0;
    end else begin
      if (fetch_grant) begin
        streak <= '0;
      end else if (load_grant && fetch_req_valid && (streak != STREAK_MAX)) begin
        streak <= streak + 1'b1;
      end
      last_addr  <= mem_addr;
      last_wdata <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl: behavioural RAM, transaction-level reference model
// compared every cycle, and hand-computed expectations for each scenario.
module tb_imem_ctrl;

  localparam int          AW  = 5;
  localparam int          MAX = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req_valid;
  logic          fetch_req_ready;
  logic [31:0]   fetch_addr;
  logic          fetch_flush;
  logic          fetch_rsp_valid;
  logic          fetch_rsp_ready;
  logic [31:0]   fetch_rsp_instr;
  logic          fetch_rsp_err;
  logic          load_valid;
  logic          load_ready;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imem_ctrl #(.AW(AW), .MAX_LOAD_BURST(MAX), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
    .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
    .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_ready(fetch_rsp_ready),
    .fetch_rsp_instr(fetch_rsp_instr), .fetch_rsp_err(fetch_rsp_err),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_data(load_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port RAM with 1-cycle read latency; read data is scrambled on non-read cycles.
  logic [31:0] ram [0:31];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) ram[i] <= 32'h100 + 32'(i);
    end else if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    else                   mem_rdata <= $urandom;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic fv, input logic [31:0] fa, input logic rr,
                               input logic fl, input logic lv, input logic [AW-1:0] la,
                               input logic [31:0] ld);
    @(posedge clk);
    #1;
    fetch_req_valid = fv;
    fetch_addr      = fa;
    fetch_rsp_ready = rr;
    fetch_flush     = fl;
    load_valid      = lv;
    load_addr       = la;
    load_data       = ld;
  endtask

  // Reference model: one outstanding response slot, a streak count and a shadow RAM.
  logic [31:0] model_ram [0:31];
  bit          m_pending;
  bit          m_err;
  logic [31:0] m_instr;
  int          m_streak;

  always @(negedge clk) begin : compare
    bit ef, el, ferr;
    if (rst) begin
      checkOutput("rst_rsp_valid", 32'(fetch_rsp_valid), 32'd0);
      checkOutput("rst_rsp_instr", fetch_rsp_instr, 32'd0);
      checkOutput("rst_req_ready", 32'(fetch_req_ready), 32'd0);
      checkOutput("rst_load_ready", 32'(load_ready), 32'd0);
      checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
      m_pending = 0;
      m_streak  = 0;
      for (int i = 0; i < 32; i++) model_ram[i] = 32'h100 + 32'(i);
    end else begin
      ferr = (fetch_addr[1:0] != 2'b00) || (fetch_addr >= 32'h80);
      ef = fetch_req_valid && (!m_pending || fetch_rsp_ready || fetch_flush) &&
           (!load_valid || m_streak == MAX);
      el = load_valid && !ef;
      checkOutput("m_rsp_valid", 32'(fetch_rsp_valid), 32'(m_pending));
      if (m_pending) begin
        checkOutput("m_rsp_instr", fetch_rsp_instr, m_instr);
        checkOutput("m_rsp_err", 32'(fetch_rsp_err), 32'(m_err));
      end
      checkOutput("m_req_ready", 32'(fetch_req_ready), 32'(ef));
      checkOutput("m_load_ready", 32'(load_ready), 32'(el));
      checkOutput("m_mem_en", 32'(mem_en), 32'((ef && !ferr) || el));
      checkOutput("m_mem_we", 32'(mem_we), 32'(el));
      if (el) begin
        checkOutput("m_wr_addr", 32'(mem_addr), 32'(load_addr));
        checkOutput("m_wr_data", mem_wdata, load_data);
        model_ram[load_addr] = load_data;
        if (fetch_req_valid && m_streak < MAX) m_streak++;
      end
      if (ef) begin
        if (!ferr) checkOutput("m_rd_addr", 32'(mem_addr), 32'(fetch_addr[AW+1:2]));
        m_pending = 1;
        m_err     = ferr;
        m_instr   = ferr ? NOP : model_ram[fetch_addr[AW+1:2]];
        m_streak  = 0;
      end else if (m_pending && (fetch_rsp_ready || fetch_flush)) begin
        m_pending = 0;
      end
    end
  end

  initial begin
    int idx;
    logic [11:0] order;

    rst = 1'b1;
    fetch_req_valid = 1'b1; fetch_addr = '0; fetch_rsp_ready = 1'b1; fetch_flush = 1'b0;
    load_valid = 1'b1; load_addr = '0; load_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_req_ready", 32'(fetch_req_ready), 32'd0);
    checkOutput("reset_load_ready", 32'(load_ready), 32'd0);
    checkOutput("reset_mem_en", 32'(mem_en), 32'd0);
    checkOutput("reset_rsp_valid", 32'(fetch_rsp_valid), 32'd0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    rst = 1'b0;

    // 1: back-to-back fetches
    for (int i = 0; i <= 8; i++) begin
      applyStimulus(i < 8, 32'(i * 4), 1, 0, 0, 0, 0);
      #2;
      if (i > 0) begin
        checkOutput("t1_valid", 32'(fetch_rsp_valid), 32'd1);
        checkOutput("t1_instr", fetch_rsp_instr, 32'h100 + 32'(i - 1));
      end
    end

    // 2: backpressure while the loader uses the port
    applyStimulus(1, 32'h8, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 32'hC, 0, 0, i < 3, 5'(20 + i), 32'hB000 + 32'(i));
      #2;
      checkOutput("t2_held_instr", fetch_rsp_instr, 32'h102);
      if (i >= 3) checkOutput("t2_req_blocked", 32'(fetch_req_ready), 32'd0);
    end
    applyStimulus(1, 32'hC, 1, 0, 0, 0, 0);
    #2;
    checkOutput("t2_req_accepted", 32'(fetch_req_ready), 32'd1);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    #2;
    checkOutput("t2_next_instr", fetch_rsp_instr, 32'h103);

    // 3: error fetches
    applyStimulus(1, 32'h6, 1, 0, 0, 0, 0);
    #2;
    checkOutput("t3_no_strobe", 32'(mem_en), 32'd0);
    checkOutput("t3_req_ready", 32'(fetch_req_ready), 32'd1);
    applyStimulus(1, 32'h80, 1, 0, 0, 0, 0);
    #2;
    checkOutput("t3_misalign_err", 32'(fetch_rsp_err), 32'd1);
    checkOutput("t3_misalign_nop", fetch_rsp_instr, NOP);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    #2;
    checkOutput("t3_range_err", 32'(fetch_rsp_err), 32'd1);
    checkOutput("t3_range_nop", fetch_rsp_instr, NOP);

    // 4: loader bursts against a continuously waiting fetch
    idx = 0;
    order = '0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1, 32'h0, 1, 0, idx < 10, 5'(8 + idx), 32'hA000 + 32'(idx));
      #2;
      order[11-c] = fetch_req_ready;
      if (load_ready) idx++;
    end
    checkOutput("t4_grant_order", 32'(order), 32'h084);
    checkOutput("t4_writes_done", 32'(idx), 32'd10);
    for (int k = 0; k <= 10; k++) begin
      applyStimulus(k < 10, 32'((8 + k) * 4), 1, 0, 0, 0, 0);
      #2;
      if (k > 0) checkOutput("t4_readback", fetch_rsp_instr, 32'hA000 + 32'(k - 1));
    end

    // 5: flush a held response together with a new fetch
    applyStimulus(1, 32'h14, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h10, 0, 1, 0, 0, 0);
    #2;
    checkOutput("t5_flush_req_ready", 32'(fetch_req_ready), 32'd1);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    #2;
    checkOutput("t5_valid", 32'(fetch_rsp_valid), 32'd1);
    checkOutput("t5_instr", fetch_rsp_instr, 32'h104);

    // 6: reset while a response is held
    applyStimulus(1, 32'h0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("t6_held_before", 32'(fetch_rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("t6_valid_in_reset", 32'(fetch_rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("t6_valid_release", 32'(fetch_rsp_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      #2;
      checkOutput("t6_valid_idle", 32'(fetch_rsp_valid), 32'd0);
    end
    applyStimulus(1, 32'h4, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    #2;
    checkOutput("t6_refetch", fetch_rsp_instr, 32'h101);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_ctrl.md
Name: imem_ctrl

Overview:
Sequencer and arbiter for the single-port synchronous instruction memory. It shares the port between two requesters: the core fetch stage (read requests with a valid/ready response channel) and the program loader (word writes). The memory has 1-cycle registered read latency. The block sits between the core's fetch stage, the loader and the instruction RAM.

Parameters:
AW, 5, word-address width; memory depth is 2**AW words.
MAX_LOAD_BURST, 4, maximum consecutive loader grants while a fetch is waiting.
NOP_INSTR, 32'h00000013, instruction returned on a fetch error.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
fetch_req_valid  in  1  fetch request valid
fetch_req_ready  out  1  fetch request accepted
fetch_addr  in  32  byte PC
fetch_flush  in  1  discard in-flight/held fetch response (redirect)
fetch_rsp_valid  out  1  response valid
fetch_rsp_ready  in  1  response consumed
fetch_rsp_instr  out  32  fetched instruction
fetch_rsp_err  out  1  misaligned or out-of-range PC
load_valid  in  1  loader write valid
load_ready  out  1  loader write accepted
load_addr  in  AW  word address
load_data  in  32  write data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory word address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid 1 cycle after a read strobe

Behaviour:
- Reset (async): fetch_rsp_valid=0, fetch_rsp_err=0, fetch_rsp_instr=0, hold register empty, load streak counter=0, no read in flight. Combinational outputs are low while reset is asserted. Reset mid-operation drops any in-flight or held response; no response appears after reset deasserts.
- Port free in cycle N: no response is held un-accepted, or the held/presented response is accepted in N (fetch_rsp_valid && fetch_rsp_ready), or fetch_flush=1 in N.
- Arbitration (port free, both valid): the loader wins. Exception: when the streak counter equals MAX_LOAD_BURST, the fetch wins. The streak counter increments on each loader grant made while fetch_req_valid=1 and resets to 0 on any fetch grant. Only one grant per cycle.
- fetch_req_ready = port free && fetch chosen. load_ready = loader chosen. Both are combinational. fetch_req_ready may depend on fetch_rsp_ready.
- Fetch grant in cycle N:
  - mem_en=1, mem_we=0, mem_addr=fetch_addr[AW+1:2].
  - In cycle N+1: fetch_rsp_valid=1 and fetch_rsp_instr=mem_rdata.
  - Throughput: 1 fetch per cycle when rsp_ready is held high.
- Fetch error: fetch_addr[1:0]!=0 or fetch_addr[31:AW+2]!=0. No memory strobe is issued. In N+1 the response is fetch_rsp_err=1, fetch_rsp_instr=NOP_INSTR.
- Backpressure: if the response is not accepted in N+1, the instruction and err bit are captured into the hold register at the next edge. They are presented unchanged until accepted, even though mem_rdata changes.
- Loader grant in cycle N: mem_en=1, mem_we=1, mem_addr=load_addr, mem_wdata=load_data. No response is produced.
- Flush in cycle N:
  - Any in-flight or held response is discarded, and fetch_rsp_valid=0 in N+1 for those.
  - A fetch accepted in the same cycle N (new PC) is kept and responds in N+1.
- With no grant: mem_en=0, mem_we=0. mem_addr and mem_wdata are don't-care but held at the last value.
- Loader write followed by a fetch of the same address in the next cycle returns the new data. This is a memory property; the controller forwards nothing.

Test Plan:
1. Reset, then 8 back-to-back fetches of PC 0,4,…,28 with rsp_ready=1 and RAM[i]=i+0x100 -> responses 0x100..0x107 on 8 consecutive cycles, starting 1 cycle after the first grant.
2. Fetch PC=8 with rsp_ready=0 for 5 cycles while the memory receives other addresses -> fetch_rsp_instr stays RAM[2]; fetch_req_ready=0 until the accepting cycle.
3. Fetch PC=0x6 -> err=1, instr=0x00000013, mem_en=0. Fetch PC=0x80 (AW=5) -> err=1.
4. load_valid held with 10 writes while fetch_req_valid=1 continuously -> grant order L,L,L,L,F,L,L,L,L,F,L,L. Written data is then read back correctly.
5. Fetch held un-accepted, fetch_flush=1 with a new fetch PC=0x10 in the same cycle -> old response never accepted; next cycle response = RAM[4].
6. Assert rst while a response is held -> fetch_rsp_valid=0 immediately and stays 0 after release until a new grant.
